// File: rtl/reg_file_pkg.sv
// Shared index map and helpers for the parametrised register file.
// Indices 0..NUM_GPR-1 are GPRs, 13 is SP, 14 is LR; 15 (PC) and the gap are unmapped.
// Combinational helpers only; no state lives here.
package reg_file_pkg;

   typedef logic [3:0] reg_idx_t;

   localparam reg_idx_t REG_SP = 4'd13;
   localparam reg_idx_t REG_LR = 4'd14;
   localparam reg_idx_t REG_PC = 4'd15;

   localparam int NUM_IDX = 16;

   // True when idx addresses real storage for a file with num_gpr GPRs.
   function automatic logic is_mapped(input reg_idx_t idx, input int num_gpr);
      return (int'(idx) < num_gpr) || (idx == REG_SP) || (idx == REG_LR);
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: index mux, optional same-edge write bypass, busy lookup.
// Latency 1 cycle from sel to data/busy.
// No backpressure; an unmapped sel leaves data and busy holding their last values.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_GPR = 8,
   parameter bit BYPASS  = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  reg_idx_t                      sel,
   input  logic [NUM_IDX-1:0][DATA_W-1:0] cur_val,
   input  logic [NUM_IDX-1:0][DATA_W-1:0] nxt_val,
   input  logic [NUM_IDX-1:0]            cur_busy,
   input  logic [NUM_IDX-1:0]            clr_busy,
   output logic [DATA_W-1:0]             data,
   output logic                          busy
);

   logic [DATA_W-1:0] pick_val;
   logic              pick_busy;

   // Bypass selects the post-write view (value and scoreboard after this edge's clear).
   always_comb begin
      pick_val  = BYPASS ? nxt_val[sel]  : cur_val[sel];
      pick_busy = BYPASS ? clr_busy[sel] : cur_busy[sel];
   end

   // Capture the selected register; unmapped indices keep the previous result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
         busy <= 1'b0;
      end else if (is_mapped(sel, NUM_GPR)) begin
         data <= pick_val;
         busy <= pick_busy;
      end
   end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: NUM_GPR GPRs plus SP/LR, NUM_RD registered read ports, busy scoreboard.
// Writes commit on the rising edge; reads return 1 cycle after sel is sampled.
// No backpressure; the dedicated SP write beats a main write to index 13 in the same cycle.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int              DATA_W  = 32,
   parameter int              NUM_GPR = 8,
   parameter int              NUM_RD  = 2,
   parameter logic [DATA_W-1:0] SP_RST = 'h1ffe,
   parameter logic [DATA_W-1:0] LR_RST = 'heeeeffff,
   parameter bit              BYPASS  = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [3:0]               wr_sel,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     sp_wr_en,
   input  logic [DATA_W-1:0]        sp_in,
   input  logic                     mark_en,
   input  logic [3:0]               mark_sel,
   input  logic [4*NUM_RD-1:0]      rd_sel,
   output logic [DATA_W*NUM_RD-1:0] data_out,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [15:0]              busy_vec
);

   logic [NUM_IDX-1:0][DATA_W-1:0] regs;
   logic [NUM_IDX-1:0][DATA_W-1:0] regs_nxt;
   logic [NUM_IDX-1:0]             busy_q;
   logic [NUM_IDX-1:0]             busy_nxt;
   logic [NUM_IDX-1:0]             busy_clr;
   logic [NUM_IDX-1:0]             commit;

   // Resolve this edge's writes: SP port has priority over a main write to index 13.
   always_comb begin
      regs_nxt = regs;
      commit   = '0;
      for (int i = 0; i < NUM_IDX; i++) begin
         logic main_hit;
         logic sp_hit;
         main_hit = wr_en && (wr_sel == reg_idx_t'(i)) && is_mapped(reg_idx_t'(i), NUM_GPR);
         sp_hit   = sp_wr_en && (reg_idx_t'(i) == REG_SP);
         commit[i] = main_hit || sp_hit;
         if (sp_hit)
            regs_nxt[i] = sp_in;
         else if (main_hit)
            regs_nxt[i] = wr_data;
      end
   end

   // Scoreboard update: a new mark outranks a completing write to the same register.
   always_comb begin
      busy_nxt = busy_q;
      busy_clr = busy_q & ~commit;
      for (int i = 0; i < NUM_IDX; i++) begin
         if (mark_en && (mark_sel == reg_idx_t'(i)) && is_mapped(reg_idx_t'(i), NUM_GPR))
            busy_nxt[i] = 1'b1;
         else if (commit[i])
            busy_nxt[i] = 1'b0;
      end
   end

   // Register storage; unmapped slots never commit and stay at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_IDX; i++)
            regs[i] <= '0;
         regs[REG_SP] <= SP_RST;
         regs[REG_LR] <= LR_RST;
      end else begin
         regs <= regs_nxt;
      end
   end

   // Scoreboard state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_nxt;
   end

   assign busy_vec = busy_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      reg_file_rd_port #(
         .DATA_W  (DATA_W),
         .NUM_GPR (NUM_GPR),
         .BYPASS  (BYPASS)
      ) u_port (
         .clk      (clk),
         .rst      (rst),
         .sel      (rd_sel[4*k +: 4]),
         .cur_val  (regs),
         .nxt_val  (regs_nxt),
         .cur_busy (busy_q),
         .clr_busy (busy_clr),
         .data     (data_out[DATA_W*k +: DATA_W]),
         .busy     (rd_busy[k])
      );
   end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the core's two-read-port register file.
- Generalised in data width, GPR count and read-port count.
- Both reads and writes occur on a single rising edge; same-cycle write-to-read bypass removes the half-cycle write trick.
- Adds a per-register busy scoreboard so the issue stage can detect pending writebacks. Sits between decode/issue and writeback.

Parameters:
- DATA_W, 32, register data width in bits.
- NUM_GPR, 8, number of general registers at indices 0..NUM_GPR-1; legal range 1..13.
- NUM_RD, 2, number of independent registered read ports; legal range 1..4.
- SP_RST, 'h1ffe, reset value of SP (index 13), zero-extended to DATA_W.
- LR_RST, 'heeeeffff, reset value of LR (index 14), truncated or extended to DATA_W.
- BYPASS, 1, 1 = forward same-cycle write data to reads; 0 = read the old value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  main write strobe.
- wr_sel  in  4  main write index.
- wr_data  in  DATA_W  main write data.
- sp_wr_en  in  1  dedicated SP write strobe.
- sp_in  in  DATA_W  dedicated SP write data.
- mark_en  in  1  set busy bit of mark_sel (instruction issued with this destination).
- mark_sel  in  4  index to mark busy.
- rd_sel  in  4*NUM_RD  read index per port; port k uses bits [4k+3:4k].
- data_out  out  DATA_W*NUM_RD  registered read data per port.
- rd_busy  out  NUM_RD  registered: selected register was busy at sample time.
- busy_vec  out  16  current scoreboard state; bit i = register i busy.

Behaviour:
- Reset, asynchronous, while rst=1:
  - GPRs = 0, SP = SP_RST, LR = LR_RST.
  - data_out = 0, rd_busy = 0, busy_vec = 0.
  - After deassertion, the first edge performs normal operation.
- Index map:
  - 0..NUM_GPR-1 = GPR.
  - 13 = SP, 14 = LR.
  - Every other index is unmapped.
- Main write, when wr_en=1 at an edge:
  - Mapped index: register takes wr_data.
  - Unmapped index: ignored.
- SP write: sp_wr_en=1 writes sp_in. If wr_en with wr_sel=13 occurs in the same cycle, sp_wr_en wins.
- Read latency: 1 cycle. data_out[k] at edge N+1 reflects rd_sel[k] sampled at edge N.
- Bypass (BYPASS=1):
  - If the read index matches a write committing at the same edge, data_out takes the written value.
  - For SP, the value is after the priority rule above.
  - With BYPASS=0, data_out takes the pre-write value.
- Unmapped read index: data_out[k] and rd_busy[k] hold their previous values.
- Read ports are fully independent; the same index on all ports is legal and each port returns identical data.
- Scoreboard, per bit i at each edge, in priority order:
  - set if mark_en and mark_sel=i;
  - else clear if a write commits to i (wr_en/wr_sel or, for i=13, sp_wr_en);
  - else hold.
- Mark and write to the same index in the same cycle leaves the bit set (new producer outstanding).
- Bits for unmapped indices are never set.
- rd_busy[k]:
  - Equals busy bit of rd_sel[k] after the same-edge clear.
  - With BYPASS=1 this means a completing write reports not busy.
  - With BYPASS=0, rd_busy uses the pre-edge bit.
- busy_vec is the registered scoreboard, with no combinational path from inputs.
- No arithmetic is performed; widths pass through unchanged. rd_sel is compared as 4-bit unsigned.

Decomposition:
- Package reg_file_pkg:
  - index constants REG_SP=4'd13, REG_LR=4'd14, REG_PC=4'd15;
  - typedef reg_idx_t (logic [3:0]);
  - function is_mapped(idx, num_gpr).
- One sub-module reg_file_rd_port: a single registered read mux with bypass and busy lookup.
- Instantiate reg_file_rd_port NUM_RD times via generate.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset, then read indices 0, 13 and 14 -> data_out = 0, 'h1ffe and 'heeeeffff respectively; busy_vec = 0.
- Write 'hA5A5_0001 to reg 3; one cycle later read reg 3 on both ports -> both ports show 'hA5A5_0001 after 1 cycle. Repeat with write and read in the same cycle: BYPASS=1 gives the new value, BYPASS=0 gives the old one.
- wr_en with wr_sel=13, wr_data='h100, together with sp_wr_en, sp_in='h200 -> SP reads 'h200. Write to index 9 -> no state change; a read of 9 holds the prior data_out.
- mark_en for reg 5 -> busy_vec[5]=1 next edge and rd_busy=1 when reg 5 is read. Then write reg 5 -> bit clears. Then mark and write reg 5 in the same cycle -> bit stays 1.
- Assert rst asynchronously mid-stream with busy bits set and data_out nonzero -> all outputs go to reset values immediately, without waiting for clk.
- NUM_GPR=13, NUM_RD=4, DATA_W=64: write distinct values to regs 0..12 and LR, then read all four ports with different indices each cycle -> every port returns its own value with 1-cycle latency.
